// File: rtl/vga_timing_detect.sv
// Recovers VGA line/frame timing from sync and data-enable, locks onto a stable mode,
// and regenerates active-pixel coordinates.
module vga_timing_detect #(
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 2047
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic        inDisplayArea,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [10:0] h_active,
  output logic [10:0] v_active,
  output logic        locked,
  output logic        lost,
  output logic        timeout
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, CHECK = 2'd2, LOCKED = 2'd3} state_t;

  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [10:0] TO_LIMIT = 11'(TIMEOUT);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    sat_inc = (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  logic hs_s1_r, hs_s2_r, vs_s1_r, vs_s2_r, de_s1_r, de_s2_r;
  logic [10:0] h_cnt_r, h_len_r, v_cnt_r, v_len_r, a_cnt_r, h_act_len_r, av_cnt_r, v_act_len_r;
  logic line_de_r, frame_act_r;
  state_t state_r, state_n;
  logic mismatch_r, mismatch_n;
  logic [3:0] match_cnt_r, match_n;
  logic [10:0] ref_h_r, ref_h_n, ref_v_r, ref_v_n;
  logic lost_n, upd_n;

  logic hs_fall_s, vs_fall_s, de_rise_s, line_first_s, to_hit_s, flag_s;
  logic [10:0] v_cnt_upd_s, h_len_cur_s, v_len_cur_s, h_act_cur_s, v_act_cur_s;
  logic [3:0] match_inc_s;

  assign hs_fall_s    = hs_s2_r & ~hs_s1_r;
  assign vs_fall_s    = vs_s2_r & ~vs_s1_r;
  assign de_rise_s    = ~de_s2_r & de_s1_r;
  // A DE clock on the hsync edge itself opens the new line.
  assign line_first_s = de_s2_r & (hs_fall_s | ~line_de_r);
  assign to_hit_s     = (h_cnt_r >= TO_LIMIT) & ~hs_fall_s;
  assign v_cnt_upd_s  = hs_fall_s ? sat_inc(v_cnt_r) : v_cnt_r;
  assign h_len_cur_s  = hs_fall_s ? h_cnt_r : h_len_r;
  assign v_len_cur_s  = vs_fall_s ? v_cnt_upd_s : v_len_r;
  // Blank lines keep the last active width so h_active survives vertical blanking.
  assign h_act_cur_s  = (hs_fall_s && (a_cnt_r != 11'd0)) ? a_cnt_r : h_act_len_r;
  assign v_act_cur_s  = vs_fall_s ? av_cnt_r : v_act_len_r;
  assign match_inc_s  = match_cnt_r + 4'd1;
  assign flag_s       = mismatch_r | (hs_fall_s & (h_cnt_r != ref_h_r))
                                   | (vs_fall_s & (v_cnt_upd_s != ref_v_r));

  // Two-stage input synchronisers, reset to each input's inactive level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1_r <= 1'b1; hs_s2_r <= 1'b1;
      vs_s1_r <= 1'b1; vs_s2_r <= 1'b1;
      de_s1_r <= 1'b0; de_s2_r <= 1'b0;
    end else begin
      hs_s1_r <= vga_h_sync;    hs_s2_r <= hs_s1_r;
      vs_s1_r <= vga_v_sync;    vs_s2_r <= vs_s1_r;
      de_s1_r <= inDisplayArea; de_s2_r <= de_s1_r;
    end
  end

  // Line, frame and active-area measurement counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r <= 11'd0; h_len_r <= 11'd0; a_cnt_r <= 11'd0; h_act_len_r <= 11'd0;
      v_cnt_r <= 11'd0; v_len_r <= 11'd0; av_cnt_r <= 11'd0; v_act_len_r <= 11'd0;
      line_de_r <= 1'b0;
    end else begin
      if (hs_fall_s) begin
        h_cnt_r   <= 11'd1;
        h_len_r   <= h_cnt_r;
        a_cnt_r   <= {10'd0, de_s2_r};
        line_de_r <= de_s2_r;
      end else begin
        h_cnt_r   <= sat_inc(h_cnt_r);
        a_cnt_r   <= de_s2_r ? sat_inc(a_cnt_r) : a_cnt_r;
        line_de_r <= line_de_r | de_s2_r;
      end
      h_act_len_r <= h_act_cur_s;
      if (vs_fall_s) begin
        v_cnt_r  <= 11'd0;
        v_len_r  <= v_cnt_upd_s;
        av_cnt_r <= {10'd0, line_first_s};
      end else begin
        v_cnt_r  <= v_cnt_upd_s;
        av_cnt_r <= line_first_s ? sat_inc(av_cnt_r) : av_cnt_r;
      end
      v_act_len_r <= v_act_cur_s;
    end
  end

  // Pixel coordinate regeneration, aligned with pixel_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0; pixel_x <= 10'd0; pixel_y <= 10'd0; frame_act_r <= 1'b0;
    end else begin
      pixel_valid <= de_s2_r;
      if (de_s2_r) begin
        pixel_x <= line_first_s ? 10'd0 : pixel_x + 10'd1;
      end else begin
        pixel_x <= pixel_x;
      end
      if (de_rise_s) begin
        pixel_y <= (frame_act_r & ~vs_fall_s) ? pixel_y + 10'd1 : 10'd0;
      end else begin
        pixel_y <= pixel_y;
      end
      if (de_s2_r) begin
        frame_act_r <= 1'b1;
      end else if (vs_fall_s) begin
        frame_act_r <= 1'b0;
      end else begin
        frame_act_r <= frame_act_r;
      end
    end
  end

  // Lock FSM next-state; the h_len comparison folds into flag_s before any vs_fall action.
  always_comb begin
    state_n    = state_r;
    mismatch_n = mismatch_r;
    match_n    = match_cnt_r;
    ref_h_n    = ref_h_r;
    ref_v_n    = ref_v_r;
    lost_n     = 1'b0;
    upd_n      = 1'b0;
    if (to_hit_s) begin
      state_n = SEARCH;
      lost_n  = (state_r == LOCKED);
    end else begin
      case (state_r)
        SEARCH: begin
          if (vs_fall_s) begin
            state_n    = MEASURE;
            mismatch_n = 1'b0;
          end else begin
            state_n = SEARCH;
          end
        end
        MEASURE: begin
          if (vs_fall_s) begin
            ref_h_n    = h_len_cur_s;
            ref_v_n    = v_len_cur_s;
            match_n    = 4'd0;
            mismatch_n = 1'b0;
            state_n    = CHECK;
          end else begin
            state_n = MEASURE;
          end
        end
        CHECK: begin
          mismatch_n = flag_s;
          if (vs_fall_s) begin
            upd_n = 1'b1;
            if (flag_s) begin
              state_n    = MEASURE;
              mismatch_n = 1'b0;
            end else begin
              match_n = match_inc_s;
              state_n = (match_inc_s >= LOCK_N) ? LOCKED : CHECK;
            end
          end else begin
            state_n = CHECK;
          end
        end
        LOCKED: begin
          mismatch_n = flag_s;
          upd_n      = vs_fall_s;
          if (flag_s) begin
            state_n = SEARCH;
            lost_n  = 1'b1;
          end else begin
            state_n = LOCKED;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  // FSM state, reference registers and status/measurement outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= SEARCH; mismatch_r <= 1'b0; match_cnt_r <= 4'd0;
      ref_h_r <= 11'd0; ref_v_r <= 11'd0;
      locked <= 1'b0; lost <= 1'b0; timeout <= 1'b0;
      h_total <= 11'd0; v_total <= 11'd0; h_active <= 11'd0; v_active <= 11'd0;
    end else begin
      state_r     <= state_n;
      mismatch_r  <= mismatch_n;
      match_cnt_r <= match_n;
      ref_h_r     <= ref_h_n;
      ref_v_r     <= ref_v_n;
      locked      <= (state_n == LOCKED);
      lost        <= lost_n;
      if (hs_fall_s) begin
        timeout <= 1'b0;
      end else if (to_hit_s) begin
        timeout <= 1'b1;
      end else begin
        timeout <= timeout;
      end
      if (upd_n) begin
        h_total  <= ref_h_r;
        v_total  <= ref_v_r;
        h_active <= h_act_cur_s;
        v_active <= v_act_cur_s;
      end else begin
        h_total  <= h_total;
        v_total  <= v_total;
        h_active <= h_active;
        v_active <= v_active;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_detect.sv
// Directed bench for vga_timing_detect using a reduced 40x12 raster (32x8 active) to keep runtime short.
module tb_vga_timing_detect;

  localparam int H = 40, HA = 32, HS0 = 34, HS1 = 38;
  localparam int V = 12, VA = 8, VS0 = 9, VS1 = 11;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic vga_h_sync = 1'b1, vga_v_sync = 1'b1, inDisplayArea = 1'b0;
  logic [9:0] pixel_x, pixel_y;
  logic pixel_valid, locked, lost, timeout;
  logic [10:0] h_total, v_total, h_active, v_active;

  int n_cmp = 0, n_err = 0;
  int lost_cnt = 0, pv_cnt = 0, l0 = 0;
  bit pix_en = 1'b0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_e;

  vga_timing_detect #(.LOCK_FRAMES(2), .TIMEOUT(2047)) dut (
    .clk(clk), .reset_n(reset_n), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .inDisplayArea(inDisplayArea), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .h_total(h_total), .v_total(v_total),
    .h_active(h_active), .v_active(v_active), .locked(locked), .lost(lost),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop expected coordinates whenever the DUT flags a valid pixel.
  always @(negedge clk) begin
    if (reset_n) begin
      if (lost) lost_cnt++;
      if (pixel_valid) begin
        pv_cnt++;
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          chk("pixel_xy", 32'({pixel_x, pixel_y}), 32'(exp_e));
        end
      end
    end
  end

  task automatic step(input logic h, input logic v, input logic de, input int x, input int y);
    vga_h_sync = h; vga_v_sync = v; inDisplayArea = de;
    if (de && pix_en) exp_q.push_back({10'(x), 10'(y)});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic run_line(input int y, input int len, input bit aligned);
    for (int x = 0; x < len; x++) begin
      logic h, v, de;
      int p;
      de = (x < HA) && (y < VA);
      h  = !((x >= HS0) && (x < HS1));
      p  = y * H + x;
      if (aligned) v = !((p >= VS0 * H + HS0) && (p < VS1 * H + HS0));
      else         v = !((y >= VS0) && (y < VS1));
      step(h, v, de, x, y);
    end
  endtask

  task automatic run_frame(input int y0, input int y1, input int short_y, input bit aligned);
    int pv0;
    bit full;
    full = pix_en && (y0 == 0) && (y1 == V - 1);
    pv0  = pv_cnt;
    for (int y = y0; y <= y1; y++) run_line(y, (y == short_y) ? H - 1 : H, aligned);
    if (full) chk("pv_per_frame", 32'(pv_cnt - pv0), 32'(HA * VA));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"},   32'({pixel_x, pixel_y, pixel_valid}), 32'd0);
    chk({tag, "_tot"},   32'({h_total, v_total}), 32'd0);
    chk({tag, "_act"},   32'({h_active, v_active}), 32'd0);
    chk({tag, "_flags"}, 32'({locked, lost, timeout}), 32'd0);
  endtask

  task automatic chk_mode(input string tag);
    chk({tag, "_h_total"},  32'(h_total),  32'(H));
    chk({tag, "_v_total"},  32'(v_total),  32'(V));
    chk({tag, "_h_active"}, 32'(h_active), 32'(HA));
    chk({tag, "_v_active"}, 32'(v_active), 32'(VA));
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_zero("init");
    idle(3);
    reset_n = 1'b1;
    pix_en  = 1'b1;

    // Initial acquisition: lock after the 4th vs_fall.
    for (int f = 0; f < 3; f++) run_frame(0, V - 1, -1, 1'b0);
    chk("lock_early", 32'(locked), 32'd0);
    run_frame(0, V - 1, -1, 1'b0);
    chk("lock_rise", 32'(locked), 32'd1);
    chk_mode("lock");
    chk("lock_no_lost", 32'(lost_cnt), 32'd0);
    chk("lock_no_timeout", 32'(timeout), 32'd0);

    // One short line while locked.
    l0 = lost_cnt;
    run_frame(0, V - 1, 3, 1'b0);
    chk("short_lost", 32'(lost_cnt - l0), 32'd1);
    chk("short_unlocked", 32'(locked), 32'd0);
    run_frame(0, V - 1, -1, 1'b0);
    run_frame(0, V - 1, -1, 1'b0);
    chk("relock_early", 32'(locked), 32'd0);
    run_frame(0, V - 1, -1, 1'b0);
    chk("relock", 32'(locked), 32'd1);
    chk("short_lost_once", 32'(lost_cnt - l0), 32'd1);

    // hsync stuck high long enough to reach TIMEOUT.
    l0 = lost_cnt;
    idle(2100);
    chk("timeout_set", 32'(timeout), 32'd1);
    chk("timeout_unlocked", 32'(locked), 32'd0);
    chk("timeout_lost", 32'(lost_cnt - l0), 32'd1);
    run_frame(0, 0, -1, 1'b0);
    chk("timeout_clear", 32'(timeout), 32'd0);
    run_frame(1, V - 1, -1, 1'b0);
    for (int f = 0; f < 3; f++) run_frame(0, V - 1, -1, 1'b0);
    chk("timeout_relock", 32'(locked), 32'd1);

    // Reset in the middle of a locked frame.
    run_frame(0, 3, -1, 1'b0);
    #2 reset_n = 1'b0;
    pix_en = 1'b0;
    exp_q.delete();
    #1 chk_zero("midrst");
    idle(3);
    reset_n = 1'b1;
    run_frame(4, V - 1, -1, 1'b0);
    pix_en = 1'b1;
    run_frame(0, V - 1, -1, 1'b0);
    run_frame(0, V - 1, -1, 1'b0);
    chk("rst_relock_early", 32'(locked), 32'd0);
    run_frame(0, V - 1, -1, 1'b0);
    chk("rst_relock", 32'(locked), 32'd1);
    chk_mode("rst");

    // vs_fall coincident with hs_fall on every frame.
    #2 reset_n = 1'b0;
    exp_q.delete();
    idle(3);
    reset_n = 1'b1;
    l0 = lost_cnt;
    for (int f = 0; f < 4; f++) run_frame(0, V - 1, -1, 1'b1);
    chk("align_lock", 32'(locked), 32'd1);
    chk_mode("align");
    run_frame(0, V - 1, -1, 1'b1);
    run_frame(0, V - 1, -1, 1'b1);
    chk("align_hold", 32'(locked), 32'd1);
    chk("align_no_lost", 32'(lost_cnt - l0), 32'd0);

    idle(10);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
